// File: rtl/deserializer_pkg.sv
// Shared definitions for the framed serial link receive side: FSM states and default word width.
package deserializer_pkg;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        RESYNC = 2'd0,
        IDLE   = 2'd1,
        SHIFT  = 2'd2
    } state_t;
endpackage

// File: rtl/deserializer_if.sv
// Serial line plus valid/ready parallel port of the deserializer.
// frame_error exists only when FRAME_ERR_EN is defined.
interface deserializer_if import deserializer_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  serial_in;
    logic                  frame_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid;
    logic                  ready;
    logic                  overrun;
    logic                  busy;
`ifdef FRAME_ERR_EN
    logic                  frame_error;
`endif

    modport slave (
        input  serial_in, frame_in, ready,
        output data_out, valid, overrun, busy
`ifdef FRAME_ERR_EN
        , frame_error
`endif
    );

    modport master (
        output serial_in, frame_in, ready,
        input  data_out, valid, overrun, busy
`ifdef FRAME_ERR_EN
        , frame_error
`endif
    );
endinterface

// File: rtl/deserializer_word_hold.sv
// Valid/ready holding register for completed words; a word arriving while the
// previous one is still unconsumed is dropped and flagged with a one-cycle overrun.
module word_hold_reg import deserializer_pkg::*; #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [DATA_WIDTH-1:0] i_word,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    output logic                  o_overrun
);
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;
    logic                  r_overrun;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_load) begin
                // Same-cycle consume frees the slot, so the new word wins.
                if (!r_valid || i_ready) begin
                    r_data  <= i_word;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;
endmodule

// File: rtl/deserializer.sv
// Framed serial receiver: LSB-first bits qualified by frame_in are reassembled into words.
// Define FRAME_ERR_EN to get a one-cycle frame_error pulse on truncated frames.
module deserializer import deserializer_pkg::*; #(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int COUNTER_SIZE = $clog2(DATA_WIDTH) + 1
) (
    input  logic           clock,
    input  logic           reset,
    deserializer_if.slave  bus
);
    localparam logic [COUNTER_SIZE-1:0] LAST_BIT = COUNTER_SIZE'(DATA_WIDTH - 1);

    state_t                  r_state;
    logic [COUNTER_SIZE-1:0] r_cnt;
    logic [DATA_WIDTH-1:0]   r_sreg;
    logic                    r_busy;
`ifdef FRAME_ERR_EN
    logic                    r_ferr;
`endif

    logic [DATA_WIDTH-1:0]   w_next;
    logic                    w_load;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_valid;
    logic                    w_overrun;

    assign w_next = {bus.serial_in, r_sreg[DATA_WIDTH-1:1]};
    // Completion is combinational so the word lands in the holding register on the last-bit edge.
    assign w_load = (r_state == SHIFT) && bus.frame_in && (r_cnt == LAST_BIT);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= RESYNC;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_busy  <= 1'b0;
`ifdef FRAME_ERR_EN
            r_ferr  <= 1'b0;
`endif
        end else begin
`ifdef FRAME_ERR_EN
            r_ferr <= 1'b0;
`endif
            case (r_state)
                RESYNC: begin
                    if (!bus.frame_in) r_state <= IDLE;
                end
                IDLE: begin
                    if (bus.frame_in) begin
                        r_sreg  <= w_next;
                        r_cnt   <= COUNTER_SIZE'(1);
                        r_state <= SHIFT;
                        r_busy  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (bus.frame_in) begin
                        r_sreg <= w_next;
                        r_cnt  <= w_load ? '0 : r_cnt + 1'b1;
                    end else begin
                        // Counter 0 here is the gap after a completed word, not a truncation.
                        r_cnt   <= '0;
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
`ifdef FRAME_ERR_EN
                        r_ferr  <= (r_cnt != '0);
`endif
                    end
                end
                default: begin
                    r_state <= RESYNC;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    word_hold_reg #(.DATA_WIDTH(DATA_WIDTH)) u_hold (
        .clock     (clock),
        .reset     (reset),
        .i_load    (w_load),
        .i_word    (w_next),
        .i_ready   (bus.ready),
        .o_data    (w_data),
        .o_valid   (w_valid),
        .o_overrun (w_overrun)
    );

    assign bus.data_out = w_data;
    assign bus.valid    = w_valid;
    assign bus.overrun  = w_overrun;
    assign bus.busy     = r_busy;
`ifdef FRAME_ERR_EN
    assign bus.frame_error = r_ferr;
`endif
endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer (W=8): directed frames, monitor checks every consumed word.
module tb_deserializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    deserializer_if #(.DATA_WIDTH(8)) dif ();
    deserializer #(.DATA_WIDTH(8)) dut (.clock(clk), .reset(rst), .bus(dif));

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];
    int busy_cnt = 0, valid_cnt = 0, ovr_cnt = 0, ferr_cnt = 0;
    int b0, v0, o0, f0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [7:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            dif.frame_in  = 1'b1;
            dif.serial_in = w[i];
        end
    endtask

    task automatic idle();
        tick();
        dif.frame_in  = 1'b0;
        dif.serial_in = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every handshake and tallies status pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (dif.busy)    busy_cnt++;
            if (dif.valid)   valid_cnt++;
            if (dif.overrun) ovr_cnt++;
`ifdef FRAME_ERR_EN
            if (dif.frame_error) ferr_cnt++;
`endif
            if (dif.valid && dif.ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word actual=%0h expected=none", dif.data_out);
                end else begin
                    chk("word", {24'd0, dif.data_out}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        dif.serial_in = 1'b0;
        dif.frame_in  = 1'b0;
        dif.ready     = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_valid", dif.valid, 1'b0);
        chk("rst_busy", dif.busy, 1'b0);
        chk("rst_data", dif.data_out, 8'h00);
        chk("rst_overrun", dif.overrun, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1: single word, ready high
        dif.ready = 1'b1;
        b0 = busy_cnt; v0 = valid_cnt;
        exp_q.push_back(8'hA5);
        send_bits(8'hA5, 8);
        idle();
        @(negedge clk);
        chk("t1_valid", dif.valid, 1'b1);
        chk("t1_data", dif.data_out, 8'hA5);
        repeat (3) tick();
        chk("t1_busy_cycles", busy_cnt - b0, 8);
        chk("t1_valid_cycles", valid_cnt - v0, 1);

        // 2: overrun while downstream stalls
        dif.ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h3C);
        send_bits(8'h3C, 8);
        send_bits(8'hC3, 8);
        idle();
        tick();
        @(negedge clk);
        chk("t2_overrun_pulses", ovr_cnt - o0, 1);
        chk("t2_valid", dif.valid, 1'b1);
        chk("t2_data", dif.data_out, 8'h3C);
        tick();
        dif.ready = 1'b1;
        tick();
        @(negedge clk);
        chk("t2_valid_after", dif.valid, 1'b0);
        chk("t2_queue", exp_q.size(), 0);

        // 3: truncated frame, then a full word proves the counter restarted
        v0 = valid_cnt; f0 = ferr_cnt;
        send_bits(8'h1F, 5);
        idle();
        tick();
        tick();
        @(negedge clk);
        chk("t3_no_valid", valid_cnt - v0, 0);
        chk("t3_busy", dif.busy, 1'b0);
`ifdef FRAME_ERR_EN
        chk("t3_frame_error", ferr_cnt - f0, 1);
`endif
        exp_q.push_back(8'h5A);
        send_bits(8'h5A, 8);
        idle();
        repeat (2) tick();
        chk("t3_word_after", valid_cnt - v0, 1);

        // 4: reset mid-frame, tail must be ignored
        send_bits(8'hFF, 4);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("t4_rst_valid", dif.valid, 1'b0);
        chk("t4_rst_busy", dif.busy, 1'b0);
        chk("t4_rst_data", dif.data_out, 8'h00);
        tick();
        rst = 1'b0;
        repeat (3) tick();
        idle();
        exp_q.push_back(8'h81);
        send_bits(8'h81, 8);
        idle();
        repeat (2) tick();
        chk("t4_queue", exp_q.size(), 0);

        // 5: continuous frame carrying two words
        b0 = busy_cnt; v0 = valid_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        send_bits(8'h12, 8);
        send_bits(8'h34, 8);
        idle();
        repeat (2) tick();
        chk("t5_valid_cycles", valid_cnt - v0, 2);
        chk("t5_overrun", ovr_cnt - o0, 0);
        chk("t5_busy_cycles", busy_cnt - b0, 16);
        chk("t5_queue", exp_q.size(), 0);

        // 6: completion coincides with consumption of the held word
        dif.ready = 1'b0;
        o0 = ovr_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send_bits(8'h55, 8);
        idle();
        tick();
        @(negedge clk);
        chk("t6_held_data", dif.data_out, 8'h55);
        send_bits(8'hAA, 7);
        tick();
        dif.frame_in  = 1'b1;
        dif.serial_in = 1'b1;
        dif.ready     = 1'b1;
        idle();
        @(negedge clk);
        chk("t6_valid", dif.valid, 1'b1);
        chk("t6_data", dif.data_out, 8'hAA);
        chk("t6_overrun", dif.overrun, 1'b0);
        repeat (3) tick();
        chk("t6_overrun_pulses", ovr_cnt - o0, 0);
        chk("final_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
